// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write arbiter for a bank of level-enabled latches.
// Each write runs setup -> enable-open -> hold so din is stable around the enable pulse.
module latch_bank_write_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DEPTH       = 8,
  parameter int WIDTH       = 8,
  parameter int OPEN_CYCLES = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*AW-1:0]    req_addr,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  output logic                   addr_err,
  output logic [WIDTH-1:0]       latch_din,
  output logic [DEPTH-1:0]       latch_enable,
  output logic                   busy
);

  // state | meaning
  // IDLE  | waiting for any req; arbitrates on the clock edge that leaves it
  // SETUP | latch_din driven with captured data, all enables low
  // OPEN  | latch_enable[addr] high for OPEN_CYCLES cycles
  // HOLD  | enables low, din held, ack/addr_err pulse, pointer advanced

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(OPEN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  din_q, din_d;
  logic [DEPTH-1:0]  en_q, en_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [PW-1:0]     pick;
  logic              addr_oor;
  logic [DEPTH-1:0]  addr_dec;

  // First requester at or after the pointer, scanning upward with wrap.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  // An out-of-range address decodes to no enable bit at all.
  always_comb begin
    addr_oor = ({1'b0, addr_q} >= (AW+1)'(DEPTH));
    addr_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_dec[i] = (addr_q == AW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    en_d    = '0;
    ack_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          addr_d  = req_addr[pick*AW +: AW];
          din_d   = req_data[pick*WIDTH +: WIDTH];
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CW'(OPEN_CYCLES - 1);
        en_d    = addr_dec;
        state_d = OPEN;
      end
      OPEN: begin
        if (cnt_q == '0) begin
          ack_d[gnt_q] = 1'b1;
          err_d        = addr_oor;
          ptr_d        = (gnt_q == PW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
          state_d      = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
          en_d  = addr_dec;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      din_q   <= '0;
      en_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      din_q   <= din_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign ack          = ack_q;
  assign addr_err     = err_q;
  assign latch_din    = din_q;
  assign latch_enable = en_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Directed bench with a write scoreboard; instance A uses defaults,
// instance B uses DEPTH=6, OPEN_CYCLES=3 for out-of-range and mid-write reset.
module tb_latch_bank_write_arbiter;

  logic clk;
  logic rst_n_a, rst_n_b;

  logic [3:0]  req_a, req_b;
  logic [11:0] addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic [3:0]  ack_a, ack_b;
  logic        err_a, err_b;
  logic [7:0]  din_a, din_b;
  logic [7:0]  en_a;
  logic [5:0]  en_b;
  logic        busy_a, busy_b;

  latch_bank_write_arbiter #(.N_REQ(4), .DEPTH(8), .WIDTH(8), .OPEN_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .req(req_a), .req_addr(addr_a), .req_data(data_a),
    .ack(ack_a), .addr_err(err_a), .latch_din(din_a), .latch_enable(en_a), .busy(busy_a)
  );

  latch_bank_write_arbiter #(.N_REQ(4), .DEPTH(6), .WIDTH(8), .OPEN_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req(req_b), .req_addr(addr_b), .req_data(data_b),
    .ack(ack_b), .addr_err(err_b), .latch_din(din_b), .latch_enable(en_b), .busy(busy_b)
  );

  typedef struct {
    logic [3:0] ack;
    logic [2:0] addr;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int multi_a = 0, multi_b = 0;
  int dinchg_a = 0, dinchg_b = 0;
  logic [7:0] prev_din_a = '0, prev_din_b = '0;
  logic [7:0] mem_a [8];
  logic [7:0] mem_b [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Latch-bank model plus glitch/one-hot watchers.
  always @(negedge clk) begin
    if ($countones(en_a) > 1) multi_a <= multi_a + 1;
    if ($countones(en_b) > 1) multi_b <= multi_b + 1;
    if (en_a != '0 && din_a !== prev_din_a) dinchg_a <= dinchg_a + 1;
    if (en_b != '0 && din_b !== prev_din_b) dinchg_b <= dinchg_b + 1;
    prev_din_a <= din_a;
    prev_din_b <= din_b;
    for (int i = 0; i < 8; i++) if (en_a[i]) mem_a[i] <= din_a;
    for (int i = 0; i < 6; i++) if (en_b[i]) mem_b[i] <= din_b;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [2:0] ad, input logic [7:0] d, input logic e);
    exp_t x;
    x.ack = a; x.addr = ad; x.data = d; x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic sb_check(input string tag, input bit use_b);
    exp_t e;
    chk({tag, "_sb_depth"}, 32'(sb_q.size() != 0), 1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk({tag, "_ack"}, 32'(use_b ? ack_b : ack_a), 32'(e.ack));
    chk({tag, "_err"}, 32'(use_b ? err_b : err_a), 32'(e.err));
    if (!e.err) chk({tag, "_latch"}, 32'(use_b ? mem_b[e.addr] : mem_a[e.addr]), 32'(e.data));
  endtask

  task automatic wait_ack(input string tag, input bit use_b, input int max);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if ((use_b ? ack_b : ack_a) != '0) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_ack_seen"}, 32'(got), 1);
  endtask

  initial begin
    int last;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    req_a = '0; addr_a = '0; data_a = '0;
    req_b = '0; addr_b = '0; data_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack_a",  32'(ack_a), 0);
    chk("rst_err_a",  32'(err_a), 0);
    chk("rst_din_a",  32'(din_a), 0);
    chk("rst_en_a",   32'(en_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_en_b",   32'(en_b), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;

    // Single write: requester 2, addr 5, data A5
    @(negedge clk);
    chk("t1_busy_idle", 32'(busy_a), 0);
    req_a = 4'b0100; addr_a[2*3 +: 3] = 3'd5; data_a[2*8 +: 8] = 8'hA5;
    push(4'b0100, 3'd5, 8'hA5, 1'b0);
    @(negedge clk);
    chk("t1_setup_busy", 32'(busy_a), 1);
    chk("t1_setup_din",  32'(din_a), 'hA5);
    chk("t1_setup_en",   32'(en_a), 0);
    chk("t1_setup_ack",  32'(ack_a), 0);
    @(negedge clk);
    chk("t1_open_en",   32'(en_a), 'b0010_0000);
    chk("t1_open_din",  32'(din_a), 'hA5);
    chk("t1_open_busy", 32'(busy_a), 1);
    chk("t1_open_ack",  32'(ack_a), 0);
    @(negedge clk);
    chk("t1_hold_en",   32'(en_a), 0);
    chk("t1_hold_busy", 32'(busy_a), 1);
    chk("t1_hold_din",  32'(din_a), 'hA5);
    sb_check("t1", 1'b0);
    req_a = '0;
    @(negedge clk);
    chk("t1_done_busy", 32'(busy_a), 0);
    chk("t1_done_ack",  32'(ack_a), 0);
    chk("t1_done_din",  32'(din_a), 'hA5);

    // All four requesting continuously after reset: order 0,1,2,3,0
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      addr_a[i*3 +: 3] = 3'(2*i);
      data_a[i*8 +: 8] = 8'(8'hC0 + i);
    end
    req_a = 4'b1111;
    push(4'b0001, 3'd0, 8'hC0, 1'b0);
    push(4'b0010, 3'd2, 8'hC1, 1'b0);
    push(4'b0100, 3'd4, 8'hC2, 1'b0);
    push(4'b1000, 3'd6, 8'hC3, 1'b0);
    push(4'b0001, 3'd0, 8'hC0, 1'b0);
    last = 0;
    for (int j = 0; j < 5; j++) begin
      wait_ack("t2", 1'b0, 12);
      sb_check("t2", 1'b0);
      if (j > 0) chk("t2_ack_spacing", 32'(cyc - last), 4);
      last = cyc;
    end
    req_a = '0;
    repeat (2) @(negedge clk);

    // Requester 1 changes data after grant; captured value must win
    req_a = 4'b0010; addr_a[1*3 +: 3] = 3'd2; data_a[1*8 +: 8] = 8'h11;
    push(4'b0010, 3'd2, 8'h11, 1'b0);
    @(negedge clk);
    chk("t3_setup_din", 32'(din_a), 'h11);
    data_a[1*8 +: 8] = 8'h22;
    @(negedge clk);
    chk("t3_open_din", 32'(din_a), 'h11);
    chk("t3_open_en",  32'(en_a), 'b0000_0100);
    wait_ack("t3", 1'b0, 6);
    chk("t3_hold_din", 32'(din_a), 'h11);
    sb_check("t3", 1'b0);
    req_a = '0;
    @(negedge clk);

    // Requester 0 drops req during OPEN; write completes, then requester 1
    rst_n_a = 1'b0;
    @(negedge clk);
    rst_n_a = 1'b1;
    @(negedge clk);
    req_a = 4'b0011;
    addr_a[0 +: 3] = 3'd1; data_a[0 +: 8] = 8'h5A;
    addr_a[3 +: 3] = 3'd6; data_a[8 +: 8] = 8'h6B;
    push(4'b0001, 3'd1, 8'h5A, 1'b0);
    push(4'b0010, 3'd6, 8'h6B, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_open_en", 32'(en_a), 'b0000_0010);
    req_a[0] = 1'b0;
    wait_ack("t4a", 1'b0, 6);
    sb_check("t4a", 1'b0);
    wait_ack("t4b", 1'b0, 8);
    sb_check("t4b", 1'b0);
    req_a = '0;
    @(negedge clk);

    // DEPTH=6, addr 7: no enable, ack and addr_err together
    req_b = 4'b0001; addr_b[0 +: 3] = 3'd7; data_b[0 +: 8] = 8'h77;
    push(4'b0001, 3'd7, 8'h77, 1'b1);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        chk("t5_en_zero", 32'(en_b), 0);
        if (ack_b != '0) begin
          got = 1'b1;
          break;
        end
      end
      chk("t5_ack_seen", 32'(got), 1);
    end
    sb_check("t5", 1'b1);
    req_b = '0;
    @(negedge clk);
    chk("t5_err_clear", 32'(err_b), 0);
    chk("t5_ack_clear", 32'(ack_b), 0);

    // Reset during OPEN (OPEN_CYCLES=3); pointer returns to requester 0
    req_b = 4'b0011;
    addr_b[0 +: 3] = 3'd2; data_b[0 +: 8] = 8'h33;
    addr_b[3 +: 3] = 3'd3; data_b[8 +: 8] = 8'h44;
    @(negedge clk);
    chk("t6_setup_din", 32'(din_b), 'h44);
    @(negedge clk);
    chk("t6_open_en", 32'(en_b), 'b00_1000);
    #2 rst_n_b = 1'b0;
    #1;
    chk("t6_rst_en",   32'(en_b), 0);
    chk("t6_rst_busy", 32'(busy_b), 0);
    chk("t6_rst_din",  32'(din_b), 0);
    chk("t6_rst_ack",  32'(ack_b), 0);
    @(negedge clk);
    chk("t6_rst_ack_hold", 32'(ack_b), 0);
    rst_n_b = 1'b1;
    push(4'b0001, 3'd2, 8'h33, 1'b0);
    wait_ack("t6a", 1'b1, 10);
    sb_check("t6a", 1'b1);
    req_b[0] = 1'b0;
    push(4'b0010, 3'd3, 8'h44, 1'b0);
    wait_ack("t6b", 1'b1, 12);
    sb_check("t6b", 1'b1);
    req_b = '0;
    repeat (2) @(negedge clk);

    chk("onehot_a",      32'(multi_a), 0);
    chk("onehot_b",      32'(multi_b), 0);
    chk("din_stable_a",  32'(dinchg_a), 0);
    chk("din_stable_b",  32'(dinchg_b), 0);
    chk("sb_drained",    32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
